// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
// Helpers work on a fixed 32-bit width; callers cast the result to their own width.
package seq_detect_pkg;

   localparam int MASK_W = 32;

   localparam logic [MASK_W-1:0] DEF_RST_PATTERN = 32'h0000_000B;
   localparam int                DEF_RST_LEN     = 4;
   localparam logic              DEF_RST_OVERLAP = 1'b0;

   // Ones in bits [len-1:0], zeros above; len=0 yields an all-zero mask.
   function automatic logic [MASK_W-1:0] len_mask(input int len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_W; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

   function automatic int clamp_len(input int len, input int max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear; clear beats increment.
module seq_match_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (res || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !(&r_cnt)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Moore serial-pattern detector with runtime pattern/length/overlap configuration,
// an input-valid qualifier and a saturating match counter.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
   parameter int                 RST_LEN     = DEF_RST_LEN,
   parameter logic               RST_OVERLAP = DEF_RST_OVERLAP
) (
   input  logic                         clk,
   input  logic                         res,
   input  logic                         en,
   input  logic                         a,
   input  logic                         cfg_we,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         cnt_clr,
   output logic                         y,
   output logic [CNT_W-1:0]             match_cnt
);

   localparam int LEN_W = $clog2(MAX_LEN+1);

   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic               r_y;

   logic [MAX_LEN-1:0] w_hist_n;
   logic [LEN_W-1:0]   w_fill_n;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_match;
   logic               w_inc;

   assign w_hist_n = {r_hist[MAX_LEN-2:0], a};
   assign w_fill_n = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
   assign w_mask   = MAX_LEN'(len_mask(int'(r_len)));

   // Candidate match for the bit on `a`; only meaningful on a sample cycle.
   assign w_match = (r_len != '0) && (w_fill_n >= r_len)
                 && ((w_hist_n & w_mask) == (r_pattern & w_mask));
   assign w_inc   = en && !cfg_we && w_match;

   always_ff @(posedge clk) begin
      if (res) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_y       <= 1'b0;
         r_pattern <= RST_PATTERN;
         r_len     <= LEN_W'(clamp_len(RST_LEN, MAX_LEN));
         r_overlap <= RST_OVERLAP;
      end else if (cfg_we) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_y       <= 1'b0;
         r_pattern <= cfg_pattern;
         r_len     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
         r_overlap <= cfg_overlap;
      end else if (en) begin
         r_hist <= w_hist_n;
         r_y    <= w_match;
         // Non-overlap restarts the fill count so the next match needs len fresh bits.
         r_fill <= (w_match && !r_overlap) ? '0 : w_fill_n;
      end else begin
         r_y <= 1'b0;
      end
   end

   seq_match_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .res   (res),
      .i_clr (cnt_clr),
      .i_inc (w_inc),
      .o_cnt (match_cnt)
   );

   assign y = r_y;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Moore serial-pattern detector, successor to the fixed 4-bit non-overlapping detectors in the sequential FSM library.
- Runtime-programmable pattern of 1..MAX_LEN bits; runtime-selectable overlap or non-overlap mode.
- Input-valid qualifier, plus a saturating match counter.
- Used standalone or as the pattern-matching front end of serial protocol blocks.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- RST_PATTERN, 8'b0000_1011, pattern loaded at reset, right-aligned.
- RST_LEN, 4, pattern length loaded at reset.
- RST_OVERLAP, 0, overlap mode loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  synchronous active-high reset.
- en  in  1  a is valid this cycle; a bit is sampled only when en=1.
- a  in  1  serial data bit.
- cfg_we  in  1  load cfg_* into the config registers.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; the first bit received is compared to bit [len-1], the last to bit [0].
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  Moore match output.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (res). Everything is sampled on the rising edge of clk.
- Reset (res=1 at an edge), highest priority:
  - hist=0, fill=0, y=0, match_cnt=0.
  - pattern/len/overlap registers take RST_PATTERN/RST_LEN/RST_OVERLAP.
  - Reset mid-sequence discards all partial progress.
- Internal state:
  - hist: MAX_LEN-bit shift register of sampled bits, newest in bit 0.
  - fill: count of bits collected since the last restart, saturating at MAX_LEN.
- Config load (cfg_we=1, res=0):
  - Latch cfg_*; clear hist and fill; y<=0.
  - Any sample offered in the same cycle (en=1) is discarded.
  - match_cnt is unaffected.
- Length rules:
  - len=0: detector never matches; samples are still shifted in.
  - len>MAX_LEN: clamped to MAX_LEN when loaded.
- Sample cycle (en=1, res=0, cfg_we=0):
  - hist_n = {hist[MAX_LEN-2:0], a}; fill_n = min(fill+1, MAX_LEN).
  - match = (len!=0) && (fill_n>=len) && (hist_n[len-1:0]==pattern[len-1:0]).
  - hist<=hist_n; y<=match.
  - On a match in non-overlap mode: fill<=0 (the next match needs len fresh bits). Otherwise fill<=fill_n.
  - There is no dead cycle after a match: the bit sampled while y=1 is the first bit of the next search.
- Idle cycle (en=0, res=0, cfg_we=0): hist and fill hold; y<=0.
- y timing:
  - Registered Moore output, high for exactly one cycle, in the cycle after the edge that sampled the final pattern bit.
  - Back-to-back matches (overlap mode) keep y high on consecutive cycles.
- match_cnt:
  - Increments on each edge where match=1; saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle (result 0).

Decomposition:
- Package seq_detect_pkg holds:
  - default constants (RST_PATTERN, RST_LEN, RST_OVERLAP);
  - a function computing the len-bit compare mask;
  - a clamp_len function.
- One sub-module: seq_match_cnt (saturating counter with sync clear and increment, CNT_W param).
- Datapath and control stay in seq_detect_param.

Test Plan:
- Reset defaults, en=1, stream 1,0,1,1,0,1,1:
  - y=1 only in the cycle after the 4th bit; match_cnt=1.
  - Same stream with cfg_overlap=1 gives a second pulse after the 7th bit; match_cnt=2.
- Load pattern 2'b11, len=2, then stream 1,1,1,1:
  - overlap=1: y high for 3 consecutive cycles (after bits 2, 3, 4).
  - overlap=0: y pulses after bits 2 and 4 only.
- Default config, stream 1,0 then en=0 for 3 cycles then 1,1:
  - y stays 0 during the gap and pulses once after the last 1.
- Stream 1,0,1; then cfg_we with the same 1011 config and en=1, a=1:
  - no match; four further bits 1,0,1,1 are required for y.
- CNT_W=2, six matches:
  - match_cnt saturates at 3.
  - cnt_clr asserted on a match edge leaves match_cnt=0.
- Load len=0, stream 8 ones: y stays 0. Separately, with defaults and stream 1,0,1:
  - asserting res at the next edge (with a=1) gives no match;
  - config returns to 1011/len 4/non-overlap; y=0.
